// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// default bit period used by both the receiver and the planned transmitter.
package uart_pkg;

    // 100 MHz system clock, 9600 baud.
    localparam logic [15:0] CLKS_PER_BIT_DEFAULT = 16'd10417;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit. The reset value is a
// parameter so that an idle-high serial line does not look like a start bit
// while the flops are coming out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the asynchronous input, then re-register it to settle metastability.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so that q picks up the
        // old value of meta, giving two real flop stages instead of one.
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver, LSB first. busy is high from the validated start-bit
// midpoint to the stop-bit midpoint; the received byte is published only at
// frame end, so downstream can latch it on the falling edge of busy.
// The byte output is named data_byte because "byte" is a reserved word.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic                      busy,
    output logic [UART_DATA_BITS-1:0] data_byte,
    output logic                      valid,
    output logic                      ferr
);

    localparam logic [15:0] HALF_BIT  = CLKS_PER_BIT / 16'd2;
    localparam logic [15:0] HALF_LAST = HALF_BIT - 16'd1;
    localparam logic [15:0] BIT_LAST  = CLKS_PER_BIT - 16'd1;
    localparam logic [2:0]  IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_t                 state;
    logic [15:0]               cnt;
    logic [2:0]                idx;
    logic [UART_DATA_BITS-1:0] shift;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame sequencer: validates the start bit, samples each bit at its
    // midpoint and drives the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            busy      <= 1'b0;
            data_byte <= '0;
            valid     <= 1'b0;
            ferr      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            busy  <= 1'b1;
                            idx   <= '0;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
                        idx   <= idx + 3'd1;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        data_byte <= shift;
                        if (rx_s) begin
                            busy  <= 1'b0;
                            valid <= 1'b1;
                            ferr  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            // Missing stop bit: hold busy until the line recovers.
                            ferr  <= 1'b1;
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte. The whole line/reset waveform is built up front;
// a frame-level decoder then predicts every output cycle from it, and one
// compare process checks the DUT against that prediction each cycle, plus a
// set of hand-derived values at key edges.
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int MAXC = 8000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       busy;
    logic [7:0] data_byte;
    logic       valid;
    logic       ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT (16'(CPB))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .busy      (busy),
        .data_byte (data_byte),
        .valid     (valid),
        .ferr      (ferr)
    );

    always #5 clk = ~clk;

    // Stimulus: value of rx / rst as seen at posedge number c.
    logic rxl  [MAXC];
    logic rstl [MAXC];
    int   n = 0;

    // Predicted outputs just after posedge number c.
    logic       e_busy  [MAXC];
    logic       e_valid [MAXC];
    logic       e_ferr  [MAXC];
    logic [7:0] e_byte  [MAXC];

    typedef struct {
        int          e;
        logic [10:0] v;
        string       name;
    } key_t;
    key_t keys[$];

    int checks   = 0;
    int failures = 0;
    int cur      = 0;
    bit running  = 1'b0;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got busy/valid/ferr/byte=%b/%b/%b/%h expected %b/%b/%b/%h",
                     name, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [10:0] pk(logic b, logic v, logic f, logic [7:0] d);
        return {b, v, f, d};
    endfunction

    // ---------------- stimulus builders ----------------
    function automatic void put(logic v, int len);
        for (int i = 0; i < len; i++) begin
            rxl[n]  = v;
            rstl[n] = 1'b0;
            n++;
        end
    endfunction

    // Start bit plus eight data bits; returns the first low edge.
    function automatic int frame_data(logic [7:0] d);
        int s;
        s = n;
        put(1'b0, CPB);
        for (int k = 0; k < 8; k++) put(d[k], CPB);
        return s;
    endfunction

    function automatic int frame(logic [7:0] d);
        int s;
        s = frame_data(d);
        put(1'b1, CPB);
        return s;
    endfunction

    function automatic void add_key(int e, logic [10:0] v, string name);
        key_t k;
        k.e = e; k.v = v; k.name = name;
        keys.push_back(k);
    endfunction

    // ---------------- behavioural model ----------------
    int   p  = 0;
    logic mb = 1'b0, mf = 1'b0;
    logic [7:0] md = 8'h00;

    function automatic void fill_to(int e);
        while (p < e && p < MAXC) begin
            e_busy[p]  = mb;
            e_valid[p] = 1'b0;
            e_ferr[p]  = mf;
            e_byte[p]  = md;
            p++;
        end
    endfunction

    // Synchronised line as used for decisions at edge c: two cycles of delay,
    // forced idle for the two edges following a reset.
    function automatic logic rxs(int c);
        if (c < 2 || c - 2 >= n) return 1'b1;
        if (rstl[c-1] || rstl[c-2]) return 1'b1;
        return rxl[c-2];
    endfunction

    function automatic int first_rst(int a, int b);
        for (int i = a; i <= b; i++) if (rstl[i]) return i;
        return -1;
    endfunction

    function automatic void build_model();
        int c, mid, s, bk, end_e, r;
        logic ok_start;
        logic [7:0] sh;
        c = 0;
        while (c < n) begin
            if (rstl[c]) begin
                fill_to(c);
                mb = 1'b0; mf = 1'b0; md = 8'h00;
                fill_to(c + 1);
                c++;
                continue;
            end
            if (rxs(c)) begin
                c++;
                continue;
            end
            // Line seen low at c: start bit is judged HALF edges later,
            // data at each following bit midpoint, stop nine bits after that.
            mid      = c + HALF;
            ok_start = !rxs(mid);
            s        = mid + 9 * CPB;
            for (int k = 0; k < 8; k++) sh[k] = rxs(mid + CPB * (k + 1));
            bk = s + 1;
            while (bk < n && !rxs(bk)) bk++;
            if (!ok_start) end_e = mid;
            else if (rxs(s)) end_e = s;
            else end_e = bk;
            if (end_e > n - 1) end_e = n - 1;
            r = first_rst(c + 1, end_e);
            if (r >= 0) begin
                if (ok_start && r > mid) begin
                    fill_to(mid); mb = 1'b1;
                    if (r > s) begin
                        fill_to(s); mf = 1'b1; md = sh;
                    end
                end
                c = r;
                continue;
            end
            if (!ok_start) begin
                c = mid + 1;
                continue;
            end
            fill_to(mid); mb = 1'b1;
            fill_to(s);   md = sh;
            if (rxs(s)) begin
                mb = 1'b0; mf = 1'b0;
                fill_to(s + 1);
                e_valid[s] = 1'b1;
                c = s + 1;
            end else begin
                mf = 1'b1;
                fill_to(bk);
                mb = 1'b0;
                c = bk + 1;
            end
        end
        fill_to(n);
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (running) begin
            check($sformatf("cycle%0d", cur), pk(busy, valid, ferr, data_byte),
                  pk(e_busy[cur], e_valid[cur], e_ferr[cur], e_byte[cur]));
            foreach (keys[i]) begin
                if (keys[i].e == cur) check(keys[i].name, pk(busy, valid, ferr, data_byte), keys[i].v);
            end
        end
    end

    // ---------------- main ----------------
    initial begin
        int s, rl, re, gap;
        logic [7:0] d;

        // Reset, then a long idle line.
        put(1'b1, 3);
        rstl[0] = 1'b1; rstl[1] = 1'b1; rstl[2] = 1'b1;
        put(1'b1, 200);
        add_key(150, pk(0, 0, 0, 8'h00), "idle_after_reset");

        // Single good frame.
        s = frame(8'hA5);
        add_key(s + 9,   pk(0, 0, 0, 8'h00), "a5_busy_not_yet");
        add_key(s + 10,  pk(1, 0, 0, 8'h00), "a5_busy_rise");
        add_key(s + 153, pk(1, 0, 0, 8'h00), "a5_busy_last");
        add_key(s + 154, pk(0, 1, 0, 8'hA5), "a5_done");
        add_key(s + 155, pk(0, 0, 0, 8'hA5), "a5_valid_one_cycle");
        put(1'b1, 20);

        // Back-to-back frames.
        s = frame(8'h00);
        add_key(s + 154, pk(0, 1, 0, 8'h00), "b2b_00");
        s = frame(8'hFF);
        add_key(s + 154, pk(0, 1, 0, 8'hFF), "b2b_ff");
        s = frame(8'h3C);
        add_key(s + 154, pk(0, 1, 0, 8'h3C), "b2b_3c");
        put(1'b1, 20);

        // Short glitch, then a good frame.
        put(1'b0, 5);
        put(1'b1, 30);
        s = frame(8'h81);
        add_key(s - 10,  pk(0, 0, 0, 8'h3C), "glitch_no_busy");
        add_key(s + 154, pk(0, 1, 0, 8'h81), "after_glitch_81");
        put(1'b1, 20);

        // Stop bit held low, line released 40 cycles after the stop bit.
        s = frame_data(8'h55);
        put(1'b0, CPB + 40);
        rl = n;
        put(1'b1, 30);
        add_key(s + 154, pk(1, 0, 1, 8'h55), "ferr_set");
        add_key(rl + 1,  pk(1, 0, 1, 8'h55), "break_hold");
        add_key(rl + 2,  pk(0, 0, 1, 8'h55), "break_release");
        s = frame(8'h12);
        add_key(s + 154, pk(0, 1, 0, 8'h12), "ferr_cleared_12");
        put(1'b1, 20);

        // Reset in the middle of the data bits.
        s = frame(8'h77);
        re = s + 40;
        rstl[re] = 1'b1;
        add_key(re - 1, pk(1, 0, 0, 8'h12), "mid_frame_busy");
        add_key(re,     pk(0, 0, 0, 8'h00), "mid_frame_reset");
        put(1'b1, 200);
        s = frame(8'h42);
        add_key(s + 154, pk(0, 1, 0, 8'h42), "after_reset_42");
        put(1'b1, 20);

        // Randomised traffic: gaps, glitches, occasional bad stop bits.
        for (int i = 0; i < 8; i++) begin
            gap = $urandom_range(0, 20);
            put(1'b1, gap);
            if ($urandom_range(0, 2) == 0) begin
                put(1'b0, $urandom_range(1, 6));
                put(1'b1, 12);
            end
            d = 8'($urandom);
            s = frame_data(d);
            if ($urandom_range(0, 3) == 0) begin
                put(1'b0, CPB + $urandom_range(0, 30));
                put(1'b1, 4);
            end else begin
                put(1'b1, CPB);
            end
        end
        put(1'b1, 300);

        build_model();

        // Pin the model against the hand-derived values.
        foreach (keys[i]) begin
            check({keys[i].name, "_model"},
                  pk(e_busy[keys[i].e], e_valid[keys[i].e], e_ferr[keys[i].e], e_byte[keys[i].e]),
                  keys[i].v);
        end

        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rx  = rxl[c];
            rst = rstl[c];
            cur = c;
            running = 1'b1;
        end
        @(negedge clk);
        running = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receive front end, 8N1, LSB first.
- Sits directly upstream of the byte-packing/memory-store stage and drives that stage's busy/byte inputs.
- The downstream stage treats a falling edge of busy as "new byte ready", so busy and byte timing here are contractual.

Parameters:
- CLKS_PER_BIT, 16'd10417, clk cycles per UART bit (100 MHz / 9600); legal range 8..65535.
- HALF_BIT, CLKS_PER_BIT/2, derived localparam; start-bit validation point.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- busy  output  1  high from validated start bit until frame completion.
- byte  output  8  last received data byte; stable from busy fall until next busy fall.
- valid  output  1  one-cycle pulse on a good frame, same cycle busy falls.
- ferr  output  1  framing error flag (sticky until next good frame).

Behaviour:
- Reset values: busy=0, byte=8'h00, valid=0, ferr=0, state=IDLE, counters=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s); all decisions below use rx_s. Total latency from a line edge is 2 cycles.
- Bit counter cnt is 16 bits; bit index is 3 bits.
- State machine:
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: cnt increments. At cnt==HALF_BIT-1, sample rx_s.
    - rx_s==0: go to DATA, busy<=1, cnt=0, idx=0.
    - rx_s==1: glitch/false start; return to IDLE with busy never asserted.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of the internal shift register (LSB first on the wire), cnt=0, idx++. After the 8th sample, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit. In either case byte<=shift.
    - rx_s==1: busy<=0, valid<=1 for one cycle, ferr<=0, go to IDLE.
    - rx_s==0: ferr<=1, go to BREAK with busy held high.
  - BREAK: wait for rx_s==1, then busy<=0 and go to IDLE. valid is not pulsed, so downstream still consumes the byte but ferr marks it bad.
- byte is written only at frame end. The shift register is separate, so byte never shows partial data.
- Busy-high duration for a good frame is exactly 9*CLKS_PER_BIT cycles (start midpoint to stop midpoint).
- Back-to-back frames: a start bit that begins immediately after the stop-bit sample is detected. The IDLE check runs in the cycle after the return from STOP.
- A line held low after reset looks like a start: it is validated, then goes through DATA → STOP → BREAK. Result: ferr=1, byte=8'h00, busy stays high until the line returns high.
- rst asserted mid-frame aborts immediately to reset values. The byte from any earlier frame is lost (byte=8'h00).
- Any illegal state encoding returns to IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK (3-bit).
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT constant, shared with the future uart_tx.
- One natural sub-module: sync_2ff (1-bit two-flop synchronizer, reset value parameterised to 1). Everything else stays in uart_rx_byte.

Test Plan:
- Reset, CLKS_PER_BIT=16, line idle, 200 cycles → busy=0, valid=0, ferr=0, byte=8'h00 throughout.
- Send 0xA5 (8N1) → busy rises 2+8 cycles after start edge and stays high 144 cycles; at its fall byte=8'hA5, valid pulses once, ferr=0.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap → three busy pulses; byte holds 00, FF, 3C in turn, each stable until the next busy fall.
- rx low for 5 cycles then high → busy never asserts; state returns to IDLE; the next frame 0x81 is received correctly.
- Frame 0x55 with stop bit forced low, line released after 40 more cycles → ferr=1, byte=8'h55, no valid, busy falls 2 cycles after rx returns high.
  - A following good frame 0x12 clears ferr to 0.
- rst pulsed for 1 cycle mid-DATA of frame 0x77 → all outputs return to reset values; the next clean frame 0x42 gives byte=8'h42.
